// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the EX-stage ALU control and the
//               iterative multiply/divide unit: ALU operation codes,
//               R-type funct values, ALUOp classes and the mul/div FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation codes driven onto ALUControle
    localparam logic [3:0] c_ALU_AND = 4'd0;
    localparam logic [3:0] c_ALU_OR  = 4'd1;
    localparam logic [3:0] c_ALU_ADD = 4'd2;
    localparam logic [3:0] c_ALU_SUB = 4'd6;
    localparam logic [3:0] c_ALU_SLT = 4'd7;
    localparam logic [3:0] c_ALU_SLL = 4'd8;
    localparam logic [3:0] c_ALU_SRL = 4'd9;
    localparam logic [3:0] c_ALU_INV = 4'd10;
    localparam logic [3:0] c_ALU_SRA = 4'd11;
    localparam logic [3:0] c_ALU_NOR = 4'd12;
    localparam logic [3:0] c_ALU_NOP = 4'd15;

    // R-type funct field values
    localparam logic [5:0] c_FN_SLL   = 6'd0;
    localparam logic [5:0] c_FN_SRL   = 6'd2;
    localparam logic [5:0] c_FN_SRA   = 6'd3;
    localparam logic [5:0] c_FN_MFHI  = 6'd16;
    localparam logic [5:0] c_FN_MTHI  = 6'd17;
    localparam logic [5:0] c_FN_MFLO  = 6'd18;
    localparam logic [5:0] c_FN_MTLO  = 6'd19;
    localparam logic [5:0] c_FN_MULT  = 6'd24;
    localparam logic [5:0] c_FN_MULTU = 6'd25;
    localparam logic [5:0] c_FN_DIV   = 6'd26;
    localparam logic [5:0] c_FN_DIVU  = 6'd27;
    localparam logic [5:0] c_FN_ADD   = 6'd32;
    localparam logic [5:0] c_FN_SUB   = 6'd34;
    localparam logic [5:0] c_FN_AND   = 6'd36;
    localparam logic [5:0] c_FN_OR    = 6'd37;
    localparam logic [5:0] c_FN_NOR   = 6'd39;
    localparam logic [5:0] c_FN_SLT   = 6'd42;

    // ALUOp classes from the main decoder
    localparam logic [1:0] c_ALUOP_MEM   = 2'd0;
    localparam logic [1:0] c_ALUOP_BR    = 2'd1;
    localparam logic [1:0] c_ALUOP_RTYPE = 2'd2;
    localparam logic [1:0] c_ALUOP_RSVD  = 2'd3;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative multiply/divide unit, one bit per cycle.
//               Shift-add multiply into a 2*WIDTH accumulator, restoring
//               divide with quotient in the low half and remainder in the
//               high half. Signed ops run on magnitudes and are sign-fixed
//               on the last edge. Owns the HI/LO architectural registers.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic             flush_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             div_zero_o
);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   m_q;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;      // product, or {remainder, quotient/dividend}
    logic               sa_q;
    logic               sb_q;
    logic               dz_q;       // current divide has a zero divisor
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               div_zero_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   dz_hi;

    // Unsigned ops pass operands through untouched; signed ops use magnitudes
    assign a_neg = is_signed_i & a_i[WIDTH-1];
    assign b_neg = is_signed_i & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // One iteration step of the active operation plus the final sign fixup
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        step_acc  = acc_q;
        if (state_q == MD_MUL) begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end else if ((state_q == MD_DIV) && !dz_q) begin
            // Borrow out of the top bit means the trial subtract failed: restore
            if (!div_diff[WIDTH]) begin
                step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
        prod_fix = (sa_q ^ sb_q) ? -step_acc : step_acc;
        quo_fix  = (sa_q ^ sb_q) ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        rem_fix  = sa_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
        // Zero divisor never iterates, so the low half still holds |rs|
        dz_hi    = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    // Sequencer: start, iterate, complete or abort; HI/LO moves while idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            if (flush_i) begin
                state_q <= MD_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    MD_IDLE: begin
                        if (start_i) begin
                            state_q    <= is_div_i ? MD_DIV : MD_MUL;
                            cnt_q      <= CNT_W'(WIDTH);
                            sa_q       <= a_neg;
                            sb_q       <= b_neg;
                            dz_q       <= is_div_i & (b_i == '0);
                            div_zero_q <= 1'b0;
                            if (is_div_i) begin
                                m_q   <= b_mag;
                                acc_q <= {{WIDTH{1'b0}}, a_mag};
                            end else begin
                                m_q   <= a_mag;
                                acc_q <= {{WIDTH{1'b0}}, b_mag};
                            end
                        end
                    end
                    default: begin
                        acc_q <= step_acc;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= MD_IDLE;
                            if (state_q == MD_MUL) begin
                                {hi_q, lo_q} <= prod_fix;
                            end else if (dz_q) begin
                                hi_q       <= dz_hi;
                                lo_q       <= '1;
                                div_zero_q <= 1'b1;
                            end else begin
                                hi_q <= rem_fix;
                                lo_q <= quo_fix;
                            end
                        end
                    end
                endcase
            end
            // The top only raises these while idle, so they never race a completion
            if (mthi_i) begin
                hi_q <= a_i;
            end
            if (mtlo_i) begin
                lo_q <= a_i;
            end
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign busy_o     = (state_q != MD_IDLE);
    assign div_zero_o = div_zero_q;

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_muldiv
// Description : EX-stage ALU control. Decodes ALUOp/funct into the 4-bit
//               ALU code, classifies HI/LO and mul/div instructions, drives
//               the hazard-unit stall and the mfhi/mflo writeback path, and
//               hosts the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Function,
    input  logic             valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [3:0]       ALUControle,
    output logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_data,
    output logic             stall,
    output logic             busy,
    output logic             div_zero
);

    logic             rtype;
    logic             md_op;
    logic             hl_op;
    logic             md_busy;
    logic             md_start;
    logic             mthi_we;
    logic             mtlo_we;
    logic             is_mfhi;
    logic             is_mflo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // ALU operation decode; HI/LO class leaves the ALU idle
    always_comb begin
        ALUControle = c_ALU_INV;
        case (ALUOp)
            c_ALUOP_MEM:  ALUControle = c_ALU_ADD;
            c_ALUOP_BR:   ALUControle = c_ALU_SUB;
            c_ALUOP_RSVD: ALUControle = c_ALU_INV;
            default: begin
                case (Function)
                    c_FN_ADD: ALUControle = c_ALU_ADD;
                    c_FN_SUB: ALUControle = c_ALU_SUB;
                    c_FN_AND: ALUControle = c_ALU_AND;
                    c_FN_OR:  ALUControle = c_ALU_OR;
                    c_FN_NOR: ALUControle = c_ALU_NOR;
                    c_FN_SLT: ALUControle = c_ALU_SLT;
                    c_FN_SLL: ALUControle = c_ALU_SLL;
                    c_FN_SRL: ALUControle = c_ALU_SRL;
                    c_FN_SRA: ALUControle = c_ALU_SRA;
                    c_FN_MFHI, c_FN_MTHI, c_FN_MFLO, c_FN_MTLO,
                    c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU:
                              ALUControle = c_ALU_NOP;
                    default:  ALUControle = c_ALU_INV;
                endcase
            end
        endcase
    end

    assign rtype = valid & (ALUOp == c_ALUOP_RTYPE);
    assign md_op = rtype & (Function inside {c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU});
    assign hl_op = rtype & (Function inside {c_FN_MFHI, c_FN_MTHI, c_FN_MFLO, c_FN_MTLO});

    // Only instructions touching HI/LO wait on the unit; plain ALU ops overlap
    assign stall    = (md_op | hl_op) & md_busy;
    assign md_start = md_op & ~md_busy & ~flush;
    assign mthi_we  = hl_op & ~md_busy & (Function == c_FN_MTHI);
    assign mtlo_we  = hl_op & ~md_busy & (Function == c_FN_MTLO);

    assign is_mfhi   = hl_op & (Function == c_FN_MFHI);
    assign is_mflo   = hl_op & (Function == c_FN_MFLO);
    assign hilo_sel  = is_mfhi | is_mflo;
    assign hilo_data = is_mfhi ? hi : (is_mflo ? lo : '0);
    assign busy      = md_busy;

    // funct[1] selects divide, funct[0] selects the unsigned variant
    muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk_i       (clock),
        .rst_ni      (reset),
        .start_i     (md_start),
        .is_div_i    (Function[1]),
        .is_signed_i (~Function[0]),
        .flush_i     (flush),
        .mthi_i      (mthi_we),
        .mtlo_i      (mtlo_we),
        .a_i         (rs_data),
        .b_i         (rt_data),
        .hi_o        (hi),
        .lo_o        (lo),
        .busy_o      (md_busy),
        .div_zero_o  (div_zero)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_muldiv
// Description : Self-checking bench for alu_ctrl_muldiv. Decode table sweep,
//               directed and random mult/div against an arithmetic model of
//               HI/LO, stall timing, flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_muldiv;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   ALUOp;
    logic [5:0]   Function;
    logic         valid;
    logic         flush;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic [3:0]   ALUControle;
    logic         hilo_sel;
    logic [W-1:0] hilo_data;
    logic         stall;
    logic         busy;
    logic         div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model state
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dz;

    alu_ctrl_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .ALUOp       (ALUOp),
        .Function    (Function),
        .valid       (valid),
        .flush       (flush),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .ALUControle (ALUControle),
        .hilo_sel    (hilo_sel),
        .hilo_data   (hilo_data),
        .stall       (stall),
        .busy        (busy),
        .div_zero    (div_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic fl);
        valid    = v;
        ALUOp    = op;
        Function = fn;
        rs_data  = a;
        rt_data  = b;
        flush    = fl;
    endtask

    // Expected ALU code straight from the instruction table
    function automatic logic [3:0] exp_code(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd3) return 4'd10;
        case (int'(fn))
            32: return 4'd2;
            34: return 4'd6;
            36: return 4'd0;
            37: return 4'd1;
            39: return 4'd12;
            42: return 4'd7;
            0:  return 4'd8;
            2:  return 4'd9;
            3:  return 4'd11;
            16, 17, 18, 19, 24, 25, 26, 27: return 4'd15;
            default: return 4'd10;
        endcase
    endfunction

    // Reference arithmetic: kind 0 mult, 1 multu, 2 div, 3 divu
    function automatic void ref_md(input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo,
                                   output logic dz);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (kind)
            0: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
                {hi, lo} = p;
            end
            1: begin
                ua = a;
                ub = b;
                p  = ua * ub;
                {hi, lo} = p;
            end
            default: begin
                if (b == '0) begin
                    hi = a;
                    lo = '1;
                    dz = 1'b1;
                end else if (kind == 2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = a;
                    hi = '0;
                end else if (kind == 2) begin
                    ia = $signed(a);
                    ib = $signed(b);
                    lo = ia / ib;
                    hi = ia % ib;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Issue one mult/div, poll mflo until served, then read HI and the flag
    task automatic run_md(input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int           n;
        logic [W-1:0] eh, el;
        logic         ed;
        ref_md(kind, a, b, eh, el, ed);
        tick();
        drive(1'b1, 2'd2, 6'(24 + kind), a, b, 1'b0);
        settle();
        check({tag, " issue_stall"}, stall, 0);
        n = 0;
        while (n <= 100) begin
            tick();
            if (n == 3) begin
                drive(1'b1, 2'd2, 6'd32, $urandom, $urandom, 1'b0);
                settle();
                check({tag, " add_stall"}, stall, 0);
                check({tag, " add_code"}, ALUControle, 4'd2);
                check({tag, " add_busy"}, busy, 1);
            end else begin
                drive(1'b1, 2'd2, 6'd18, $urandom, $urandom, 1'b0);
                settle();
                if (!stall) break;
            end
            n++;
        end
        check({tag, " stall_cycles"}, n, W);
        check({tag, " lo"}, hilo_data, el);
        check({tag, " mflo_sel"}, hilo_sel, 1);
        tick();
        drive(1'b1, 2'd2, 6'd16, $urandom, $urandom, 1'b0);
        settle();
        check({tag, " hi"}, hilo_data, eh);
        check({tag, " mfhi_stall"}, stall, 0);
        check({tag, " div_zero"}, div_zero, ed);
        m_hi = eh;
        m_lo = el;
        m_dz = ed;
    endtask

    initial begin
        logic [5:0]   fn;
        logic [W-1:0] ra, rb;
        int           kind, sel;

        // Reset state
        reset = 1'b0;
        drive(1'b1, 2'd2, 6'd16, '0, '0, 1'b0);
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        #3;
        check("rst busy", busy, 0);
        check("rst stall", stall, 0);
        check("rst hilo_data", hilo_data, 0);
        check("rst div_zero", div_zero, 0);
        tick();
        tick();
        reset = 1'b1;

        // Decode sweep: non-R-type classes with random funct
        for (int op = 0; op < 4; op++) begin
            if (op == 2) continue;
            fn = 6'($urandom);
            tick();
            drive(1'b1, 2'(op), fn, '0, '0, 1'b1);
            settle();
            check($sformatf("dec op%0d fn%0d", op, fn), ALUControle, exp_code(2'(op), fn));
            check($sformatf("dec op%0d stall", op), stall, 0);
        end
        // All funct values under R-type; flush holds off any mul/div start
        for (int f = 0; f < 64; f++) begin
            tick();
            drive(1'b1, 2'd2, 6'(f), '0, '0, 1'b1);
            settle();
            check($sformatf("dec fn%0d", f), ALUControle, exp_code(2'd2, 6'(f)));
            check($sformatf("dec fn%0d stall", f), stall, 0);
            check($sformatf("dec fn%0d sel", f), hilo_sel, (f == 16 || f == 18));
        end
        tick();
        drive(1'b0, 2'd0, 6'd0, '0, '0, 1'b0);
        settle();
        check("dec no_start", busy, 0);

        // Directed arithmetic cases
        run_md(0, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
        run_md(1, 32'hFFFF_FFFD, 32'd7, "multu");
        run_md(2, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        run_md(3, 32'd100, 32'd0, "divu 100/0");
        run_md(2, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
        run_md(2, 32'hFFFF_FFF9, 32'd0, "div -7/0");

        // Random mix including zero divisors and the overflow pair
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            sel  = int'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(1, 20)); end
            run_md(kind, ra, rb, $sformatf("rnd%0d k%0d", i, kind));
        end

        // Flush mid-multiply; mthi while busy must stall and not write
        tick();
        drive(1'b1, 2'd2, 6'd17, 32'hAAAA_0000, '0, 1'b0);
        settle();
        check("mthi idle stall", stall, 0);
        tick();
        drive(1'b1, 2'd2, 6'd19, 32'h0000_5555, '0, 1'b0);
        settle();
        m_hi = 32'hAAAA_0000;
        m_lo = 32'h0000_5555;
        tick();
        drive(1'b1, 2'd2, 6'd24, 32'd12345, 32'd678, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) begin
                drive(1'b1, 2'd2, 6'd17, 32'hDEAD_BEEF, '0, 1'b0);
                settle();
                check("mthi busy stall", stall, 1);
            end else begin
                drive(1'b0, 2'd2, 6'd0, '0, '0, (i == 9));
                settle();
            end
        end
        check("flush pre busy", busy, 1);
        tick();
        drive(1'b1, 2'd2, 6'd16, '0, '0, 1'b0);
        settle();
        check("flush busy", busy, 0);
        check("flush hi kept", hilo_data, m_hi);
        tick();
        drive(1'b1, 2'd2, 6'd18, '0, '0, 1'b0);
        settle();
        check("flush lo kept", hilo_data, m_lo);
        // Mul/div presented together with flush is dropped
        tick();
        drive(1'b1, 2'd2, 6'd24, 32'd3, 32'd5, 1'b1);
        settle();
        tick();
        drive(1'b1, 2'd2, 6'd18, '0, '0, 1'b0);
        settle();
        check("flush start blocked", busy, 0);
        check("flush start lo", hilo_data, m_lo);

        // Asynchronous reset in the middle of a divide
        tick();
        drive(1'b1, 2'd2, 6'd27, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1'b0, 2'd0, 6'd0, '0, '0, 1'b0);
        end
        tick();
        check("pre reset busy", busy, 1);
        reset = 1'b0;
        drive(1'b1, 2'd2, 6'd16, '0, '0, 1'b0);
        #1;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        check("async rst busy", busy, 0);
        check("async rst hi", hilo_data, m_hi);
        check("async rst stall", stall, 0);
        Function = 6'd18;
        #1;
        check("async rst lo", hilo_data, m_lo);
        check("async rst dz", div_zero, m_dz);
        tick();
        reset = 1'b1;
        drive(1'b1, 2'd2, 6'd19, 32'h0000_1234, '0, 1'b0);
        settle();
        m_lo = 32'h0000_1234;
        tick();
        drive(1'b1, 2'd2, 6'd18, '0, '0, 1'b0);
        settle();
        check("mtlo mflo", hilo_data, m_lo);
        check("mtlo mflo sel", hilo_sel, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
